// File: rtl/jk_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_sched_pkg : op encoding and FSM state type for the JK scheduler |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jk_sched_pkg;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } jk_op_t;

   typedef logic [0:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE  = 1'b0;
   localparam fsm_state_t ST_APPLY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_cell : edge-triggered JK flip-flop with async active-high reset |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            2'b11:   r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_bank_scheduler : two-requester round-robin command scheduler    |
// | driving a bank of JK cells. Rev 1.0                                |
// +--------------------------------------------------------------------+
module jk_bank_scheduler #(
   parameter int NUM_FF = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [1:0]        req0_op,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [1:0]        req1_op,
   output logic              req1_ready,
   output logic [NUM_FF-1:0] q,
   output logic [NUM_FF-1:0] q_bar,
   output logic              busy,
   output logic              done,
   output logic              done_id,
   output logic              err
);

   import jk_sched_pkg::*;

   fsm_state_t        r_state;
   logic              r_last;
   logic [ADDR_W-1:0] r_addr;
   jk_op_t            r_op;
   logic              r_id;
   logic              r_done;
   logic              r_done_id;
   logic              r_err;

   logic              w_idle;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_xfer;
   logic              w_addr_ok;
   logic              w_op_j;
   logic              w_op_k;
   logic [NUM_FF-1:0] w_j;
   logic [NUM_FF-1:0] w_k;

   // Ready is gated by rst so the handshake is dead the instant reset rises.
   assign w_idle     = (r_state == ST_IDLE) && !rst;
   assign w_grant0   = w_idle && req0_valid && (!req1_valid || r_last);
   assign w_grant1   = w_idle && req1_valid && (!req0_valid || !r_last);
   assign w_xfer     = w_grant0 || w_grant1;
   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign w_addr_ok  = (32'(r_addr) < NUM_FF);
   assign w_op_j     = (r_op == OP_SET)   || (r_op == OP_TOGGLE);
   assign w_op_k     = (r_op == OP_RESET) || (r_op == OP_TOGGLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_last    <= 1'b1;
         r_addr    <= '0;
         r_op      <= OP_HOLD;
         r_id      <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_addr  <= w_grant1 ? req1_addr : req0_addr;
                  r_op    <= jk_op_t'(w_grant1 ? req1_op : req0_op);
                  r_id    <= w_grant1;
                  r_last  <= w_grant1;
                  r_state <= ST_APPLY;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_done    <= 1'b1;
               r_done_id <= r_id;
               r_err     <= !w_addr_ok;
            end
         endcase
      end
   end

   // Out-of-range addresses match no cell, so the whole bank holds.
   generate
      for (genvar i = 0; i < NUM_FF; i++) begin : g_cell
         logic w_hit;
         assign w_hit  = (r_state == ST_APPLY) && (32'(r_addr) == i);
         assign w_j[i] = w_hit && w_op_j;
         assign w_k[i] = w_hit && w_op_k;

         jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (w_j[i]),
            .k   (w_k[i]),
            .q   (q[i])
         );
      end
   endgenerate

   assign q_bar   = ~q;
   assign busy    = (r_state == ST_APPLY);
   assign done    = r_done;
   assign done_id = r_done_id;
   assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jk_bank_scheduler : scoreboard bench, two banks (4 and 3 cells) |
// | sharing one stimulus stream. Rev 1.0                               |
// +--------------------------------------------------------------------+
module tb_jk_bank_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1;
   logic [1:0] a0, a1, o0, o1;

   logic       rdy0_a, rdy1_a, busy_a, done_a, did_a, err_a;
   logic [3:0] q_a, qb_a;
   logic       rdy0_b, rdy1_b, busy_b, done_b, did_b, err_b;
   logic [2:0] q_b, qb_b;

   always #5 clk = ~clk;

   jk_bank_scheduler #(.NUM_FF(4), .ADDR_W(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_addr(a0), .req0_op(o0), .req0_ready(rdy0_a),
      .req1_valid(v1), .req1_addr(a1), .req1_op(o1), .req1_ready(rdy1_a),
      .q(q_a), .q_bar(qb_a), .busy(busy_a), .done(done_a), .done_id(did_a), .err(err_a)
   );

   jk_bank_scheduler #(.NUM_FF(3), .ADDR_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_addr(a0), .req0_op(o0), .req0_ready(rdy0_b),
      .req1_valid(v1), .req1_addr(a1), .req1_op(o1), .req1_ready(rdy1_b),
      .q(q_b), .q_bar(qb_b), .busy(busy_b), .done(done_b), .done_id(did_b), .err(err_b)
   );

   typedef struct {
      int id;
      int q4;
      int err4;
      int q3;
      int err3;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: one command in flight at most.
   int   m_busy = 0;
   int   m_done = 0;
   int   m_last = 1;
   int   m_q4   = 0;
   int   m_q3   = 0;
   exp_t m_pend;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int apply_op(input int qv, input int addr, input int op, input int n);
      if (addr >= n) return qv;
      case (op)
         1:       return qv & ~(1 << addr);
         2:       return qv | (1 << addr);
         3:       return qv ^ (1 << addr);
         default: return qv;
      endcase
   endfunction

   function automatic int winner(input int rv0, input int rv1, input int last);
      if (rv0 != 0 && rv1 != 0) return (last == 1) ? 0 : 1;
      if (rv0 != 0) return 0;
      if (rv1 != 0) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin : p_model
      int g, addr, op;
      if (rst) begin
         m_busy = 0; m_done = 0; m_last = 1; m_q4 = 0; m_q3 = 0;
         sb.delete();
      end else begin
         m_done = 0;
         if (m_busy != 0) begin
            m_busy = 0;
            m_done = 1;
            m_q4   = m_pend.q4;
            m_q3   = m_pend.q3;
         end else begin
            g = winner(int'(v0), int'(v1), m_last);
            if (g >= 0) begin
               addr        = (g == 1) ? int'(a1) : int'(a0);
               op          = (g == 1) ? int'(o1) : int'(o0);
               m_pend.id   = g;
               m_pend.q4   = apply_op(m_q4, addr, op, 4);
               m_pend.err4 = (addr >= 4) ? 1 : 0;
               m_pend.q3   = apply_op(m_q3, addr, op, 3);
               m_pend.err3 = (addr >= 3) ? 1 : 0;
               sb.push_back(m_pend);
               m_last = g;
               m_busy = 1;
            end
         end
      end
   end

   always @(negedge clk) begin : p_monitor
      int   g, e_r0, e_r1, e_busy, e_q4, e_q3, e_done;
      exp_t ent;
      if (rst) begin
         e_r0 = 0; e_r1 = 0; e_busy = 0; e_q4 = 0; e_q3 = 0; e_done = 0;
      end else begin
         g      = (m_busy != 0) ? -1 : winner(int'(v0), int'(v1), m_last);
         e_r0   = (g == 0) ? 1 : 0;
         e_r1   = (g == 1) ? 1 : 0;
         e_busy = m_busy;
         e_q4   = m_q4;
         e_q3   = m_q3;
         e_done = m_done;
      end
      chk("ready0_a", int'(rdy0_a), e_r0);
      chk("ready1_a", int'(rdy1_a), e_r1);
      chk("ready0_b", int'(rdy0_b), e_r0);
      chk("ready1_b", int'(rdy1_b), e_r1);
      chk("busy_a", int'(busy_a), e_busy);
      chk("busy_b", int'(busy_b), e_busy);
      chk("q_a", int'(q_a), e_q4);
      chk("q_b", int'(q_b), e_q3);
      chk("qbar_a", int'(qb_a), (~e_q4) & 15);
      chk("qbar_b", int'(qb_b), (~e_q3) & 7);
      chk("done_a", int'(done_a), e_done);
      chk("done_b", int'(done_b), e_done);
      if (done_a || e_done != 0) begin
         if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
         end else begin
            ent = sb.pop_front();
            chk("done_id_a", int'(did_a), ent.id);
            chk("done_id_b", int'(did_b), ent.id);
            chk("err_a", int'(err_a), ent.err4);
            chk("err_b", int'(err_b), ent.err3);
            chk("done_q_a", int'(q_a), ent.q4);
            chk("done_q_b", int'(q_b), ent.q3);
         end
      end
   end

   task automatic drive(input logic iv0, input logic [1:0] ia0, input logic [1:0] io0,
                        input logic iv1, input logic [1:0] ia1, input logic [1:0] io1,
                        input int n);
      v0 = iv0; a0 = ia0; o0 = io0;
      v1 = iv1; a1 = ia1; o1 = io1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; o0 = '0; o1 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 2);

      // Set then toggle cell 2 from requester 0.
      drive(1, 2, 2'b10, 0, 0, 0, 2);
      chk("set_a2_q", int'(q_a), 4);
      chk("set_a2_done", int'(done_a), 1);
      chk("set_a2_done_id", int'(did_a), 0);
      drive(1, 2, 2'b11, 0, 0, 0, 2);
      chk("toggle_a2_q", int'(q_a), 0);
      drive(0, 0, 0, 0, 0, 0, 2);

      // Tie from reset: requester 0 first, then 1.
      do_reset(2);
      drive(1, 0, 2'b10, 1, 1, 2'b10, 4);
      chk("tie_q_a", int'(q_a), 3);
      chk("tie_last_done_id", int'(did_a), 1);
      drive(0, 0, 0, 0, 0, 0, 1);

      // Continuous contention over four commands.
      drive(1, 3, 2'b11, 1, 2, 2'b11, 8);
      chk("fair_q_a", int'(q_a), 3);
      chk("fair_q_b", int'(q_b), 3);
      drive(0, 0, 0, 0, 0, 0, 1);

      // Address 3 is out of range only for the 3-cell bank.
      drive(0, 0, 0, 1, 3, 2'b10, 2);
      chk("badaddr_err_b", int'(err_b), 1);
      chk("badaddr_done_b", int'(done_b), 1);
      chk("badaddr_err_a", int'(err_a), 0);
      chk("badaddr_q_b", int'(q_b), 3);
      drive(0, 0, 0, 0, 0, 0, 1);

      // Reset lands while a command is in APPLY.
      do_reset(1);
      drive(1, 1, 2'b10, 0, 0, 0, 1);
      chk("abort_busy_before", int'(busy_a), 1);
      rst = 1'b1;
      v0  = 1'b0;
      #1;
      chk("abort_busy_async", int'(busy_a), 0);
      chk("abort_qbar_async", int'(qb_a), 15);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_no_done", int'(done_a), 0);
      chk("abort_q", int'(q_a), 0);
      drive(1, 1, 2'b10, 0, 0, 0, 2);
      chk("after_abort_q", int'(q_a), 2);
      drive(0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jk_bank_scheduler.md
JK_BANK_SCHEDULER -- requirements
Module: jk_bank_scheduler

Interface
REQ-001 SHALL have parameter NUM_FF, default 4: number of JK cells in the bank.
REQ-002 SHALL have parameter ADDR_W, default 2: cell address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 command present.
REQ-006 SHALL have port req0_addr, input, ADDR_W bits: requester 0 target cell.
REQ-007 SHALL have port req0_op, input, 2 bits: requester 0 operation.
REQ-008 SHALL have port req0_ready, output, 1 bit: requester 0 command accepted this cycle.
REQ-009 SHALL have ports req1_valid, req1_addr, req1_op and req1_ready, identical to REQ-005..008, for requester 1.
REQ-010 SHALL have port q, output, NUM_FF bits: bank state.
REQ-011 SHALL have port q_bar, output, NUM_FF bits: bitwise complement of q.
REQ-012 SHALL have port busy, output, 1 bit: FSM is not in IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after a command has been applied.
REQ-014 SHALL have port done_id, output, 1 bit: requester that owns the completed command.
REQ-015 SHALL have port err, output, 1 bit: qualifies done; the address was at or above NUM_FF.

Function
REQ-016 SHALL encode op as: 00 HOLD (J=0,K=0); 01 RESET (J=0,K=1); 10 SET (J=1,K=0); 11 TOGGLE (J=1,K=1).
REQ-017 SHALL implement a two-state FSM: IDLE and APPLY.
REQ-018 SHALL assert at most one reqN_ready, and only in IDLE.
REQ-019 SHALL assert reqN_ready combinationally, in the same cycle, when requester N is the arbitration winner.
REQ-020 SHALL define a transfer as valid and ready both high at a rising edge.
REQ-021 SHALL, on a transfer, latch addr, op and the requester id, then move to APPLY.
REQ-022 SHALL, in APPLY, drive J/K only to the addressed cell; all other cells get J=0, K=0.
REQ-023 SHALL update the addressed cell at the edge that leaves APPLY, then return to IDLE.
REQ-024 SHALL therefore give a latency of 2 edges from transfer edge T: q valid after edge T+1.
REQ-025 SHALL give a throughput of one command per 2 cycles.
REQ-026 SHALL register done=1 and done_id for exactly the one cycle after edge T+1.
REQ-027 SHALL allow a new transfer in the same cycle that done is high.
REQ-028 SHALL arbitrate round-robin using a last_grant register.
REQ-029 SHALL, when both requesters are valid, grant the requester that is not last_grant.
REQ-030 SHALL, when only one requester is valid, grant it.
REQ-031 SHALL update last_grant only on a transfer.
REQ-032 SHALL keep req*_valid, addr and op sampled only at the transfer edge; input changes during APPLY have no effect.
REQ-033 SHALL, for addr >= NUM_FF, accept the command, change no cell, and pulse err together with done.
REQ-034 SHALL hold q when a HOLD op completes; done still pulses.
REQ-035 SHALL invert the addressed bit when a TOGGLE op completes.
REQ-036 SHALL have q_bar == ~q at all times, including during reset.

Reset
REQ-037 SHALL, while rst=1, immediately force: q=0, q_bar=all ones, FSM=IDLE, busy=0, done=0, done_id=0, err=0, both ready=0.
REQ-038 SHALL set last_grant=1 on reset, so requester 0 wins the first tie.
REQ-039 SHALL abort a command in APPLY when rst asserts: no cell update and no done pulse.

Structure
REQ-040 SHALL place the op encoding (HOLD/RESET/SET/TOGGLE) and the FSM state type in shared package jk_sched_pkg.
REQ-041 SHALL instantiate NUM_FF copies of sub-module jk_cell: an edge-triggered JK cell with the same clk/rst, ports j, k, q.
REQ-042 SHALL keep the arbiter and FSM in jk_bank_scheduler; no other sub-modules.

Verification
REQ-043 SHALL cover reset: rst=1 then 0 -> q=0000, q_bar=1111, busy=0, no ready.
REQ-044 SHALL cover set/toggle: req0 SET addr2 transfers at T -> q=0100 after T+1; done=1, done_id=0; then req0 TOGGLE addr2 -> q=0000.
REQ-045 SHALL cover tie arbitration: both valid (req0 SET a0, req1 SET a1) -> req0 granted first, then req1; q=0011; done_id sequence 0,1.
REQ-046 SHALL cover fairness: both valid continuously for 4 commands -> grants alternate 0,1,0,1; no ready in APPLY cycles.
REQ-047 SHALL cover bad address: NUM_FF=3, req1 SET addr3 -> q unchanged, err=1 with done.
REQ-048 SHALL cover reset mid-command: rst during APPLY of SET addr1 -> q=0000, no done; next command proceeds normally.
